// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encoding, default divider latency and stage indices.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV      = 2'd1,
    ST_EXC_PEND = 2'd2
  } ctrl_state_e;

  localparam int DIV_LAT_DEFAULT = 32;

  // Stage indices used to address the per-stage stall/flush vectors.
  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

endpackage

// File: rtl/pipe_div_timer.sv
// Loadable down-counter that tracks how many divide cycles remain.
// The count is the number of cycles still to spend in DIV, including the
// current one, so o_last marks the final occupied cycle.
module pipe_div_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: clear beats load beats decrement; saturates at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Merges memory
// wait states, exceptions, multi-cycle divide and load-use hazards into
// per-stage hold/clear controls with zero-cycle latency.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEFAULT,
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_req_busy,
  input  logic d_req_busy,
  input  logic div_start,
  input  logic load_use,
  input  logic exc_valid,
  output logic stall_f,
  output logic stall_d,
  output logic stall_e,
  output logic stall_m,
  output logic stall_w,
  output logic flush_d,
  output logic flush_e,
  output logic flush_m,
  output logic flush_w,
  output logic div_busy,
  output logic exc_pending
);

  ctrl_state_e          r_state;
  ctrl_state_e          w_next;
  logic                 w_mem_stall;
  logic [STG_W:STG_F]   w_stall;
  logic [STG_W:STG_D]   w_flush;
  logic                 w_load;
  logic                 w_dec;
  logic                 w_clr;
  logic                 w_last;
  logic                 w_div_busy;
  logic                 w_exc_pend;

  // Remaining cycles after the start cycle, which itself counts as occupancy.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_LAT - 1);

  assign w_mem_stall = i_req_busy | d_req_busy;

  pipe_div_timer #(.CNT_W(CNT_W)) u_div_timer (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .i_clr      (w_clr),
    .o_last     (w_last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-stage controls; priority mem > exception > divide > load-use.
  always_comb begin
    w_stall    = '0;
    w_flush    = '0;
    w_next     = r_state;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_clr      = 1'b0;
    w_div_busy = 1'b0;
    w_exc_pend = 1'b0;
    if (!resetn) begin
      w_next = ST_IDLE;
    end else begin
      w_div_busy = (r_state == ST_DIV);
      // An exception seen during a memory stall is already waiting for memory.
      w_exc_pend = (r_state == ST_EXC_PEND) | (w_mem_stall & exc_valid);
      if (w_mem_stall) begin
        w_stall = '1;
        if (exc_valid && (r_state != ST_EXC_PEND)) begin
          w_next = ST_EXC_PEND;
        end else begin
          w_next = r_state;
        end
      end else if (exc_valid || (r_state == ST_EXC_PEND)) begin
        // Single flush for live and pending exceptions; aborts any divide.
        w_flush[STG_D] = 1'b1;
        w_flush[STG_E] = 1'b1;
        w_flush[STG_M] = 1'b1;
        w_flush[STG_W] = 1'b1;
        w_next         = ST_IDLE;
        w_clr          = 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (div_start) begin
              w_stall[STG_F] = 1'b1;
              w_stall[STG_D] = 1'b1;
              w_stall[STG_E] = 1'b1;
              w_flush[STG_M] = 1'b1;
              w_load         = 1'b1;
              w_next         = ST_DIV;
            end else if (load_use) begin
              w_stall[STG_F] = 1'b1;
              w_stall[STG_D] = 1'b1;
              w_flush[STG_E] = 1'b1;
            end else begin
              w_next = ST_IDLE;
            end
          end
          ST_DIV: begin
            // E is held, so load-use and new div_start are irrelevant here.
            w_stall[STG_F] = 1'b1;
            w_stall[STG_D] = 1'b1;
            w_stall[STG_E] = 1'b1;
            w_flush[STG_M] = 1'b1;
            w_dec          = 1'b1;
            if (w_last) begin
              w_next = ST_IDLE;
            end else begin
              w_next = ST_DIV;
            end
          end
          default: begin
            w_next = ST_IDLE;
          end
        endcase
      end
    end
  end

  assign stall_f     = w_stall[STG_F];
  assign stall_d     = w_stall[STG_D];
  assign stall_e     = w_stall[STG_E];
  assign stall_m     = w_stall[STG_M];
  assign stall_w     = w_stall[STG_W];
  assign flush_d     = w_flush[STG_D];
  assign flush_e     = w_flush[STG_E];
  assign flush_m     = w_flush[STG_M];
  assign flush_w     = w_flush[STG_W];
  assign div_busy    = w_div_busy;
  assign exc_pending = w_exc_pend;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed output vectors.
// Output vector order: {sf,sd,se,sm,sw, fd,fe,fm,fw, div_busy, exc_pending}.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic resetn;
  logic i_req_busy, d_req_busy, div_start, load_use, exc_valid;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w;
  logic div_busy, exc_pending;

  int errors = 0;
  int checks = 0;

  localparam logic [10:0] V_ZERO   = 11'b00000_0000_00;
  localparam logic [10:0] V_LU     = 11'b11000_0100_00;
  localparam logic [10:0] V_DSTART = 11'b11100_0010_00;
  localparam logic [10:0] V_DIV    = 11'b11100_0010_10;
  localparam logic [10:0] V_DIVMEM = 11'b11111_0000_10;
  localparam logic [10:0] V_MEM    = 11'b11111_0000_00;
  localparam logic [10:0] V_MEMEXC = 11'b11111_0000_01;
  localparam logic [10:0] V_FLUSH  = 11'b00000_1111_00;
  localparam logic [10:0] V_FLPEND = 11'b00000_1111_01;
  localparam logic [10:0] V_FLDIV  = 11'b00000_1111_10;

  pipe_hazard_ctrl #(.DIV_LAT(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_req_busy  (i_req_busy),
    .d_req_busy  (d_req_busy),
    .div_start   (div_start),
    .load_use    (load_use),
    .exc_valid   (exc_valid),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .stall_m     (stall_m),
    .stall_w     (stall_w),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .flush_m     (flush_m),
    .flush_w     (flush_w),
    .div_busy    (div_busy),
    .exc_pending (exc_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {stall_f, stall_d, stall_e, stall_m, stall_w,
            flush_d, flush_e, flush_m, flush_w, div_busy, exc_pending};
  endfunction

  // Start a new cycle just after the rising edge and apply inputs.
  task automatic drive(input logic ib, input logic db, input logic ds,
                       input logic lu, input logic ex);
    @(posedge clk);
    #1;
    i_req_busy = ib;
    d_req_busy = db;
    div_start  = ds;
    load_use   = lu;
    exc_valid  = ex;
  endtask

  // Compare outputs against the expected vector at once (mid-cycle).
  task automatic check_now(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare outputs on the falling edge of the current cycle.
  task automatic check(input string tag, input logic [10:0] exp);
    @(negedge clk);
    check_now(tag, exp);
  endtask

  initial begin
    // Reset with every input high: outputs forced low.
    resetn = 1'b0;
    i_req_busy = 1'b1; d_req_busy = 1'b1; div_start = 1'b1;
    load_use = 1'b1; exc_valid = 1'b1;
    #12;
    check_now("reset_inputs_high", V_ZERO);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_inputs_low", V_ZERO);
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_idle", V_ZERO);

    // Load-use hazard for one cycle.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("load_use", V_LU);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_use_after", V_ZERO);

    // Divide of 32 cycles; div_start and load_use inside DIV are ignored.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("div_c1", V_DSTART);
    for (int c = 2; c <= 32; c++) begin
      drive(1'b0, 1'b0, (c == 5), (c == 6), 1'b0);
      check($sformatf("div_c%0d", c), V_DIV);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("div_done", V_ZERO);

    // Divide with 5 memory-stall cycles (11..15): 37 cycles total.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("divm_c1", V_DSTART);
    for (int c = 2; c <= 37; c++) begin
      if (c >= 11 && c <= 15) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check($sformatf("divm_c%0d", c), V_DIVMEM);
      end else begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check($sformatf("divm_c%0d", c), V_DIV);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("divm_done", V_ZERO);

    // Exception during a 3-cycle data stall, flushed when memory frees.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("excm_c1", V_MEMEXC);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("excm_c2", V_MEMEXC);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("excm_c3", V_MEMEXC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("excm_flush", V_FLPEND);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("excm_after", V_ZERO);

    // Second exception merges with a pending one (fetch stall): one flush.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("merge_c1", V_MEMEXC);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("merge_c2", V_MEMEXC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("merge_flush", V_FLPEND);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("merge_after", V_ZERO);

    // Exception at divide cycle 10 aborts the divide.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("dexc_c1", V_DSTART);
    for (int c = 2; c <= 9; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("dexc_c%0d", c), V_DIV);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("dexc_flush", V_FLDIV);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dexc_after", V_ZERO);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dexc_after2", V_ZERO);

    // Exception, div_start and load_use together: only the flush.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("all3_flush", V_FLUSH);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("all3_no_div", V_ZERO);

    // Memory stall alone in IDLE.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("mem_only", V_MEM);

    // Reset in the middle of a divide loses the state.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rdiv_c1", V_DSTART);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rdiv_c2", V_DIV);
    resetn = 1'b0;
    #1;
    check_now("rdiv_in_reset", V_ZERO);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    check("rdiv_released", V_ZERO);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rdiv_idle", V_ZERO);

    // Reset while an exception is pending: no flush afterwards.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rexc_c1", V_MEMEXC);
    resetn = 1'b0;
    #1;
    check_now("rexc_in_reset", V_ZERO);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    check("rexc_no_flush", V_ZERO);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rexc_idle", V_ZERO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
